tlb_op_ctrl: RTL and testbench

- Sequences the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR from the pipeline onto the MMU's TLB read/write/probe interface.
- Owns the Random register.
- Returns probe and read results to CP0 as write-enable pulses.
- Requests a pipeline flush after any op that can invalidate registered translations; the pipeline stalls on op_ready while an op is in flight.

---
 rtl/tlb_op_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// CP0 TLB instruction sequencer: TLBP/TLBR/TLBWI/TLBWR onto the MMU port.
// Also owns the CP0 Random register.
package tlb_op_ctrl_pkg;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [15:0] mask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_TLBWR = 2'b11
    } tlb_op_e;

endpackage

module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES),
    parameter int LOOKUP_LAT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    output logic             op_done,
    input  logic [31:0]      cp0_index,
    input  logic [31:0]      cp0_wired,
    input  logic             wired_we,
    input  logic [31:0]      cp0_entry_hi,
    input  tlb_entry_t       cp0_entry,
    output logic [IDX_W-1:0] tlbrw_index,
    output logic             tlbrw_we,
    output tlb_entry_t       tlbrw_wdata,
    input  tlb_entry_t       tlbrw_rdata,
    output logic [31:0]      tlbp_entry_hi,
    input  logic [31:0]      tlbp_index,
    output logic             index_we,
    output logic [31:0]      index_wdata,
    output logic             entry_we,
    output tlb_entry_t       entry_rdata,
    output logic [IDX_W-1:0] random,
    output logic             flush_req
);

    localparam int CNT_W = $clog2(LOOKUP_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_V   = CNT_W'(LOOKUP_LAT);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLB_ENTRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic [CNT_W-1:0]  r_cnt;
    tlb_op_e           r_op;
    logic [IDX_W-1:0]  r_idx;
    tlb_entry_t        r_wdata;
    logic [31:0]       r_ehi;
    logic [IDX_W-1:0]  r_random;
    logic [31:0]       r_index_q;
    tlb_entry_t        r_entry_q;
    logic [IDX_W-1:0]  w_wired;
    logic              w_unused;

    assign w_wired  = cp0_wired[IDX_W-1:0];
    assign w_unused = ^{cp0_index[31:IDX_W], cp0_wired[31:IDX_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Pulses are gated by reset so an abort never leaks a strobe or result.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        op_ready  = 1'b0;
        tlbrw_we  = 1'b0;
        op_done   = 1'b0;
        index_we  = 1'b0;
        entry_we  = 1'b0;
        flush_req = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tlbrw_we = !reset && (r_op == OP_TLBWI || r_op == OP_TLBWR);
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                op_done   = !reset;
                index_we  = !reset && (r_op == OP_TLBP);
                entry_we  = !reset && (r_op == OP_TLBR);
                flush_req = !reset && (r_op != OP_TLBP);
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= OP_TLBP;
            r_idx   <= '0;
            r_wdata <= '0;
            r_ehi   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= tlb_op_e'(op_code);
                r_wdata <= cp0_entry;
                r_ehi   <= cp0_entry_hi;
                r_idx   <= (op_code == OP_TLBWR) ? r_random
                                                 : cp0_index[IDX_W-1:0];
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= LAT_V;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_index_q <= '0;
            r_entry_q <= '0;
        end else begin
            if (index_we) begin
                r_index_q <= tlbp_index;
            end
            if (entry_we) begin
                r_entry_q <= tlbrw_rdata;
            end
        end
    end

    // Random counts down through [wired, max] and wraps back to max.
    always_ff @(posedge clk) begin
        if (reset || wired_we) begin
            r_random <= MAX_IDX;
        end else if (w_wired >= MAX_IDX) begin
            r_random <= MAX_IDX;
        end else if (r_random <= w_wired) begin
            r_random <= MAX_IDX;
        end else begin
            r_random <= r_random - IDX_W'(1);
        end
    end

    assign index_wdata   = index_we ? tlbp_index : r_index_q;
    assign entry_rdata   = entry_we ? tlbrw_rdata : r_entry_q;
    assign tlbrw_index   = r_idx;
    assign tlbrw_wdata   = r_wdata;
    assign tlbp_entry_hi = r_ehi;
    assign random        = r_random;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: cycle-level transaction model plus directed
// vectors with hand-computed expectations.
module tb_tlb_op_ctrl;
    import tlb_op_ctrl_pkg::*;

    localparam int N        = 16;
    localparam int IW       = 4;
    localparam int LAT      = 1;
    localparam int DONE_AGE = 2 + LAT;

    logic          clk;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op_code;
    logic          op_done;
    logic [31:0]   cp0_index;
    logic [31:0]   cp0_wired;
    logic          wired_we;
    logic [31:0]   cp0_entry_hi;
    tlb_entry_t    cp0_entry;
    logic [IW-1:0] tlbrw_index;
    logic          tlbrw_we;
    tlb_entry_t    tlbrw_wdata;
    tlb_entry_t    tlbrw_rdata;
    logic [31:0]   tlbp_entry_hi;
    logic [31:0]   tlbp_index;
    logic          index_we;
    logic [31:0]   index_wdata;
    logic          entry_we;
    tlb_entry_t    entry_rdata;
    logic [IW-1:0] random;
    logic          flush_req;

    int n_vec = 0;
    int n_err = 0;

    tlb_op_ctrl #(
        .TLB_ENTRIES(N),
        .IDX_W(IW),
        .LOOKUP_LAT(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_code(op_code),
        .op_done(op_done),
        .cp0_index(cp0_index),
        .cp0_wired(cp0_wired),
        .wired_we(wired_we),
        .cp0_entry_hi(cp0_entry_hi),
        .cp0_entry(cp0_entry),
        .tlbrw_index(tlbrw_index),
        .tlbrw_we(tlbrw_we),
        .tlbrw_wdata(tlbrw_wdata),
        .tlbrw_rdata(tlbrw_rdata),
        .tlbp_entry_hi(tlbp_entry_hi),
        .tlbp_index(tlbp_index),
        .index_we(index_we),
        .index_wdata(index_wdata),
        .entry_we(entry_we),
        .entry_rdata(entry_rdata),
        .random(random),
        .flush_req(flush_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tlb_entry_t mk(int i);
        tlb_entry_t e;
        e      = '0;
        e.vpn2 = 19'(i * 977 + 3);
        e.asid = 8'(i + 1);
        e.pfn0 = 20'(i * 4099);
        e.pfn1 = 20'(~i);
        e.c0   = 3'(i);
        e.v1   = 1'b1;
        return e;
    endfunction

    // MMU stand-in: each TLB slot holds mk(slot), one cycle of read latency.
    always @(posedge clk) tlbrw_rdata <= mk(int'(tlbrw_index));

    task automatic cmp(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: m_age counts cycles since accept (-1 = idle).
    int         m_age   = -1;
    int         m_rand  = N - 1;
    logic [1:0] m_op    = 2'b00;
    int         m_idx   = 0;
    tlb_entry_t m_wdata = '0;
    logic [31:0] m_ehi  = '0;
    logic [31:0] m_lasti = '0;
    tlb_entry_t m_laste = '0;

    always @(negedge clk) begin : model
        logic       e_done, e_we, e_iwe, e_ewe, e_fl;
        logic [31:0] e_iw;
        tlb_entry_t e_er;
        int         w;
        e_done = (m_age == DONE_AGE) && !reset;
        e_we   = (m_age == 1) && m_op[1] && !reset;
        e_iwe  = e_done && (m_op == 2'b00);
        e_ewe  = e_done && (m_op == 2'b01);
        e_fl   = e_done && (m_op != 2'b00);
        e_iw   = e_iwe ? tlbp_index : m_lasti;
        e_er   = e_ewe ? mk(m_idx) : m_laste;
        cmp("m_ready", 128'(op_ready), 128'(m_age < 0));
        cmp("m_we", 128'(tlbrw_we), 128'(e_we));
        cmp("m_done", 128'(op_done), 128'(e_done));
        cmp("m_index_we", 128'(index_we), 128'(e_iwe));
        cmp("m_entry_we", 128'(entry_we), 128'(e_ewe));
        cmp("m_flush", 128'(flush_req), 128'(e_fl));
        cmp("m_random", 128'(random), 128'(m_rand));
        cmp("m_rw_index", 128'(tlbrw_index), 128'(m_idx));
        cmp("m_wdata", 128'(tlbrw_wdata), 128'(m_wdata));
        cmp("m_probe_key", 128'(tlbp_entry_hi), 128'(m_ehi));
        cmp("m_index_wdata", 128'(index_wdata), 128'(e_iw));
        cmp("m_entry_rdata", 128'(entry_rdata), 128'(e_er));
        if (reset) begin
            m_age   = -1;
            m_rand  = N - 1;
            m_op    = 2'b00;
            m_idx   = 0;
            m_wdata = '0;
            m_ehi   = '0;
            m_lasti = '0;
            m_laste = '0;
        end else begin
            if (e_iwe) m_lasti = e_iw;
            if (e_ewe) m_laste = e_er;
            if (m_age < 0) begin
                if (op_valid) begin
                    m_op    = op_code;
                    m_idx   = (op_code == 2'b11) ? m_rand : int'(cp0_index[IW-1:0]);
                    m_wdata = cp0_entry;
                    m_ehi   = cp0_entry_hi;
                    m_age   = 1;
                end
            end else if (m_age == DONE_AGE) begin
                m_age = -1;
            end else begin
                m_age++;
            end
            w = int'(cp0_wired[IW-1:0]);
            if (wired_we || w >= N - 1 || m_rand <= w) m_rand = N - 1;
            else m_rand = m_rand - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [1:0] code);
        op_code  = code;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    initial begin
        bit found;
        reset        = 1'b1;
        op_valid     = 1'b0;
        op_code      = 2'b00;
        cp0_index    = '0;
        cp0_wired    = 32'd4;
        wired_we     = 1'b0;
        cp0_entry_hi = '0;
        cp0_entry    = '0;
        tlbp_index   = '0;
        tick();
        tick();
        cmp("rst_ready", 128'(op_ready), 128'(1));
        cmp("rst_random", 128'(random), 128'(15));
        cmp("rst_rw_index", 128'(tlbrw_index), 128'(0));
        cmp("rst_done", 128'(op_done), 128'(0));
        cmp("rst_flush", 128'(flush_req), 128'(0));
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            cmp("rand_seq", 128'(random), 128'((i < 12) ? 15 - i : 15));
            tick();
        end
        cmp("rand_after_wrap", 128'(random), 128'(14));
        tick();
        tick();
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        cmp("wired_we_reload", 128'(random), 128'(15));
        tick();
        cmp("after_reload", 128'(random), 128'(14));
        cp0_wired = 32'd15;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("all_wired", 128'(random), 128'(15));
        end
        cp0_wired = 32'd4;
        tick();

        cmp("wi_ready", 128'(op_ready), 128'(1));
        cp0_index = 32'd5;
        cp0_entry = mk(100);
        start(2'b10);
        cp0_index = 32'd9;
        cp0_entry = mk(101);
        cmp("wi_we", 128'(tlbrw_we), 128'(1));
        cmp("wi_index", 128'(tlbrw_index), 128'(5));
        cmp("wi_wdata", 128'(tlbrw_wdata), 128'(mk(100)));
        cmp("wi_busy", 128'(op_ready), 128'(0));
        tick();
        cmp("wi_we_wait", 128'(tlbrw_we), 128'(0));
        tick();
        cmp("wi_done", 128'(op_done), 128'(1));
        cmp("wi_flush", 128'(flush_req), 128'(1));
        cmp("wi_index_we", 128'(index_we), 128'(0));
        cmp("wi_entry_we", 128'(entry_we), 128'(0));
        tick();
        cmp("wi_ready_back", 128'(op_ready), 128'(1));

        cp0_entry_hi = 32'h1234_5000;
        tlbp_index   = 32'h0000_0007;
        start(2'b00);
        cmp("p_key", 128'(tlbp_entry_hi), 128'(32'h1234_5000));
        cmp("p_no_we", 128'(tlbrw_we), 128'(0));
        tick();
        tick();
        cmp("p_hit_we", 128'(index_we), 128'(1));
        cmp("p_hit_val", 128'(index_wdata), 128'(7));
        cmp("p_hit_flush", 128'(flush_req), 128'(0));
        tick();
        tlbp_index = 32'h8000_0000;
        #1;
        cmp("p_hold", 128'(index_wdata), 128'(7));
        start(2'b00);
        tick();
        tick();
        cmp("p_miss_we", 128'(index_we), 128'(1));
        cmp("p_miss_val", 128'(index_wdata), 128'(32'h8000_0000));
        cmp("p_miss_flush", 128'(flush_req), 128'(0));
        tick();

        cp0_index = 32'd3;
        start(2'b01);
        tick();
        tick();
        cmp("r_entry_we", 128'(entry_we), 128'(1));
        cmp("r_entry", 128'(entry_rdata), 128'(mk(3)));
        cmp("r_flush", 128'(flush_req), 128'(1));
        tick();

        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (random == 4'd9) found = 1'b1;
            else tick();
        end
        cmp("wr_found_9", 128'(found), 128'(1));
        cp0_entry = mk(200);
        start(2'b11);
        cmp("wr_index", 128'(tlbrw_index), 128'(9));
        cmp("wr_random_moved", 128'(random), 128'(8));
        cmp("wr_we", 128'(tlbrw_we), 128'(1));
        tick();
        tick();
        cmp("wr_flush", 128'(flush_req), 128'(1));
        tick();

        cp0_index = 32'd3;
        start(2'b01);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmp("ab_ready", 128'(op_ready), 128'(1));
        cmp("ab_done", 128'(op_done), 128'(0));
        cmp("ab_entry_we", 128'(entry_we), 128'(0));
        cmp("ab_flush", 128'(flush_req), 128'(0));
        tick();
        cmp("ab_done2", 128'(op_done), 128'(0));

        cp0_index = 32'd5;
        cp0_entry = mk(300);
        op_code   = 2'b10;
        op_valid  = 1'b1;
        tick();
        op_code      = 2'b00;
        cp0_index    = 32'd6;
        cp0_entry_hi = 32'hABCD_E000;
        tlbp_index   = 32'h0000_000B;
        cmp("bz_we", 128'(tlbrw_we), 128'(1));
        cmp("bz_index", 128'(tlbrw_index), 128'(5));
        tick();
        cmp("bz_busy", 128'(op_ready), 128'(0));
        tick();
        cmp("bz_done", 128'(op_done), 128'(1));
        cmp("bz_index_we", 128'(index_we), 128'(0));
        tick();
        cmp("bz_ready", 128'(op_ready), 128'(1));
        tick();
        op_valid = 1'b0;
        cmp("bz2_no_we", 128'(tlbrw_we), 128'(0));
        cmp("bz2_key", 128'(tlbp_entry_hi), 128'(32'hABCD_E000));
        cmp("bz2_index", 128'(tlbrw_index), 128'(6));
        tick();
        tick();
        cmp("bz2_index_we", 128'(index_we), 128'(1));
        cmp("bz2_val", 128'(index_wdata), 128'(32'hB));
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
